// File: rtl/distance_feeder_pkg.sv
// Shared definitions for the distance feeder: default geometry of a KNN
// sample, the feeder FSM state type and a small arithmetic helper.
package distance_feeder_pkg;

    localparam int unsigned DEF_M            = 60;
    localparam int unsigned DEF_N            = 10;
    localparam int unsigned DEF_W            = 32;
    localparam int unsigned DEF_MAX_ELEMENTS = 30;
    localparam int unsigned DEF_TYPE_W       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_WAIT_REQ,
        ST_WAIT_DONE,
        ST_RESULT
    } feeder_state_e;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/feeder_burst_buffer.sv
// Burst staging buffer: two DEPTH-word register files (training and input)
// written one slot at a time, cleared in bulk, read as flattened buses.
//   clk, rst             clock, asynchronous active-low reset
//   clr                  zero every slot of both files
//   wr_en, wr_idx        write train_wr / input_wr into slot wr_idx
//   train_flat           training words, slot k at [k*W +: W]
//   input_flat           input words, same layout
module feeder_burst_buffer #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 30,
    parameter int unsigned IW    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [IW-1:0]      wr_idx,
    input  logic [W-1:0]       train_wr,
    input  logic [W-1:0]       input_wr,
    output logic [DEPTH*W-1:0] train_flat,
    output logic [DEPTH*W-1:0] input_flat
);

    logic [W-1:0] train_q [DEPTH];
    logic [W-1:0] train_d [DEPTH];
    logic [W-1:0] input_q [DEPTH];
    logic [W-1:0] input_d [DEPTH];

    always_comb begin
        train_d = train_q;
        input_d = input_q;
        if (clr) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                train_d[k] = '0;
                input_d[k] = '0;
            end
        end else if (wr_en) begin
            train_d[wr_idx] = train_wr;
            input_d[wr_idx] = input_wr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            train_q <= '{default: '0};
            input_q <= '{default: '0};
        end else begin
            train_q <= train_d;
            input_q <= input_d;
        end
    end

    always_comb begin
        train_flat = '0;
        input_flat = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            train_flat[k*W +: W] = train_q[k];
            input_flat[k*W +: W] = input_q[k];
        end
    end

endmodule

// File: rtl/distance_feeder.sv
// Producer side of the distance_calculator burst protocol. On start it reads
// one training vector and one input vector (M*N words each) from two sync
// RAMs, presents them in bursts of MAX_ELEMENTS words with a ready pulse,
// waits for data_request between bursts and for done after the last one,
// then captures distance/type for the voter.
//   clk, rst                       clock, asynchronous active-low reset
//   start, sample_type             begin a sample (IDLE only), its label
//   rd_en, rd_addr                 shared read strobe/address of both RAMs
//   train_rd_data, input_rd_data   RAM data, one cycle after rd_en
//   training_data, input_data      burst buses, word k at [k*W +: W]
//   training_data_type             latched sample label
//   ready                          one-cycle pulse, burst valid
//   data_request, done             calculator handshakes
//   distance, data_type            calculator result, valid with done
//   busy                           high outside IDLE
//   result_valid/distance/type     captured result, one-cycle valid pulse
//   proto_err                      sticky: done arrived before the last burst
module distance_feeder
    import distance_feeder_pkg::*;
#(
    parameter int unsigned M            = DEF_M,
    parameter int unsigned N            = DEF_N,
    parameter int unsigned W            = DEF_W,
    parameter int unsigned MAX_ELEMENTS = DEF_MAX_ELEMENTS,
    parameter int unsigned TYPE_W       = DEF_TYPE_W,
    localparam int unsigned AW          = $clog2(M*N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [TYPE_W-1:0]         sample_type,
    output logic                      rd_en,
    output logic [AW-1:0]             rd_addr,
    input  logic [W-1:0]              train_rd_data,
    input  logic [W-1:0]              input_rd_data,
    output logic [MAX_ELEMENTS*W-1:0] training_data,
    output logic [MAX_ELEMENTS*W-1:0] input_data,
    output logic [TYPE_W-1:0]         training_data_type,
    output logic                      ready,
    input  logic                      data_request,
    input  logic                      done,
    input  logic [W-1:0]              distance,
    input  logic [TYPE_W-1:0]         data_type,
    output logic                      busy,
    output logic                      result_valid,
    output logic [W-1:0]              result_distance,
    output logic [TYPE_W-1:0]         result_type,
    output logic                      proto_err
);

    localparam int unsigned MN = M * N;
    localparam int unsigned PW = $clog2(MN + 1);
    localparam int unsigned CW = $clog2(MAX_ELEMENTS + 1);
    localparam int unsigned IW = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;

    feeder_state_e     state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     fidx_q, fidx_d;
    logic [CW-1:0]     len_q, len_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [W-1:0]      rdist_q, rdist_d;
    logic [TYPE_W-1:0] rtype_q, rtype_d;
    logic              perr_q, perr_d;

    logic              buf_clr;
    logic              buf_wr_en;
    logic [IW-1:0]     buf_wr_idx;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        fidx_d       = fidx_q;
        len_d        = len_q;
        type_d       = type_q;
        rdist_d      = rdist_q;
        rtype_d      = rtype_q;
        perr_d       = perr_q;
        rd_en        = 1'b0;
        ready        = 1'b0;
        result_valid = 1'b0;
        buf_clr      = 1'b0;
        buf_wr_en    = 1'b0;
        buf_wr_idx   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    type_d  = sample_type;
                    ptr_d   = '0;
                    fidx_d  = '0;
                    len_d   = CW'(min_u(MAX_ELEMENTS, MN));
                    buf_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            // fidx counts FETCH cycles: reads issue while fidx < len, and each
            // read lands one cycle later in slot fidx-1, so the burst ends
            // on the cycle fidx == len (no read, last slot written).
            ST_FETCH: begin
                if (fidx_q < len_q) begin
                    rd_en = 1'b1;
                    ptr_d = ptr_q + PW'(1);
                end
                if (fidx_q != '0) begin
                    buf_wr_en  = 1'b1;
                    buf_wr_idx = IW'(fidx_q - CW'(1));
                end
                if (fidx_q == len_q) begin
                    state_d = ST_PRESENT;
                end else begin
                    fidx_d = fidx_q + CW'(1);
                end
            end
            ST_PRESENT: begin
                ready   = 1'b1;
                state_d = (ptr_q == PW'(MN)) ? ST_WAIT_DONE : ST_WAIT_REQ;
            end
            ST_WAIT_REQ: begin
                if (done) begin
                    perr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (data_request) begin
                    fidx_d  = '0;
                    len_d   = CW'(min_u(MAX_ELEMENTS, MN - 32'(ptr_q)));
                    buf_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    rdist_d = distance;
                    rtype_d = data_type;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                result_valid = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            fidx_q  <= '0;
            len_q   <= '0;
            type_q  <= '0;
            rdist_q <= '0;
            rtype_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fidx_q  <= fidx_d;
            len_q   <= len_d;
            type_q  <= type_d;
            rdist_q <= rdist_d;
            rtype_q <= rtype_d;
            perr_q  <= perr_d;
        end
    end

    feeder_burst_buffer #(
        .W     (W),
        .DEPTH (MAX_ELEMENTS),
        .IW    (IW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clr        (buf_clr),
        .wr_en      (buf_wr_en),
        .wr_idx     (buf_wr_idx),
        .train_wr   (train_rd_data),
        .input_wr   (input_rd_data),
        .train_flat (training_data),
        .input_flat (input_data)
    );

    assign rd_addr            = rd_en ? AW'(ptr_q) : '0;
    assign training_data_type = type_q;
    assign busy               = (state_q != ST_IDLE);
    assign result_distance    = rdist_q;
    assign result_type        = rtype_q;
    assign proto_err          = perr_q;

endmodule

// File: tb/tb_distance_feeder.sv
module tb_distance_feeder;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: M=2, N=3, ME=4 ----------------
    logic         a_start, a_dreq, a_done, a_rd_en, a_ready, a_busy, a_rv, a_perr;
    logic [1:0]   a_type, a_tdt, a_data_type, a_rtype;
    logic [2:0]   a_rd_addr;
    logic [31:0]  a_train_rd, a_input_rd, a_distance, a_rdist;
    logic [127:0] a_training_data, a_input_data;
    logic [31:0]  a_train [8];

    distance_feeder #(.M(2), .N(3), .W(32), .MAX_ELEMENTS(4), .TYPE_W(2)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .sample_type(a_type),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .train_rd_data(a_train_rd), .input_rd_data(a_input_rd),
        .training_data(a_training_data), .input_data(a_input_data),
        .training_data_type(a_tdt), .ready(a_ready),
        .data_request(a_dreq), .done(a_done),
        .distance(a_distance), .data_type(a_data_type),
        .busy(a_busy), .result_valid(a_rv),
        .result_distance(a_rdist), .result_type(a_rtype), .proto_err(a_perr)
    );
    always @(posedge clk) if (a_rd_en) a_train_rd <= a_train[a_rd_addr];
    assign a_input_rd = '0;

    // ---------------- instance B: M=2, N=2, ME=4 ----------------
    logic         b_start, b_dreq, b_done, b_rd_en, b_ready, b_busy, b_rv, b_perr;
    logic [1:0]   b_type, b_tdt, b_data_type, b_rtype;
    logic [1:0]   b_rd_addr;
    logic [31:0]  b_train_rd, b_input_rd, b_distance, b_rdist;
    logic [127:0] b_training_data, b_input_data;
    logic [31:0]  b_train [4];

    distance_feeder #(.M(2), .N(2), .W(32), .MAX_ELEMENTS(4), .TYPE_W(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .sample_type(b_type),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .train_rd_data(b_train_rd), .input_rd_data(b_input_rd),
        .training_data(b_training_data), .input_data(b_input_data),
        .training_data_type(b_tdt), .ready(b_ready),
        .data_request(b_dreq), .done(b_done),
        .distance(b_distance), .data_type(b_data_type),
        .busy(b_busy), .result_valid(b_rv),
        .result_distance(b_rdist), .result_type(b_rtype), .proto_err(b_perr)
    );
    always @(posedge clk) if (b_rd_en) b_train_rd <= b_train[b_rd_addr];
    assign b_input_rd = '0;

    // ---------------- instance C: defaults ----------------
    logic         c_start, c_dreq, c_done, c_rd_en, c_ready, c_busy, c_rv, c_perr;
    logic [1:0]   c_type, c_tdt, c_data_type, c_rtype;
    logic [9:0]   c_rd_addr;
    logic [31:0]  c_train_rd, c_input_rd, c_distance, c_rdist;
    logic [959:0] c_training_data, c_input_data;
    logic [31:0]  c_train [1024];
    logic [31:0]  c_inp   [1024];

    distance_feeder u_c (
        .clk(clk), .rst(rst), .start(c_start), .sample_type(c_type),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr),
        .train_rd_data(c_train_rd), .input_rd_data(c_input_rd),
        .training_data(c_training_data), .input_data(c_input_data),
        .training_data_type(c_tdt), .ready(c_ready),
        .data_request(c_dreq), .done(c_done),
        .distance(c_distance), .data_type(c_data_type),
        .busy(c_busy), .result_valid(c_rv),
        .result_distance(c_rdist), .result_type(c_rtype), .proto_err(c_perr)
    );
    always @(posedge clk) begin
        if (c_rd_en) begin
            c_train_rd <= c_train[c_rd_addr];
            c_input_rd <= c_inp[c_rd_addr];
        end
    end

    int c_hits [1024];
    int c_rd_total  = 0;
    int c_ready_cnt = 0;
    always @(negedge clk) begin
        if (c_rd_en) begin
            c_hits[c_rd_addr]++;
            c_rd_total++;
        end
        if (c_ready) c_ready_cnt++;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_a_ready(input string name);
        int n = 0;
        while (a_ready !== 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
        end
        check(name, a_ready, 1'b1);
    endtask

    task automatic wait_c_ready(input string name);
        int n = 0;
        while (c_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check(name, c_ready, 1'b1);
    endtask

    function automatic logic [127:0] words4(input int w0, input int w1, input int w2, input int w3);
        return {32'(w3), 32'(w2), 32'(w1), 32'(w0)};
    endfunction

    typedef struct {
        logic         start, dreq, done;
        logic         e_rd_en;
        logic [2:0]   e_addr;
        logic         e_ready, e_busy, e_rv, chk_bus;
        logic [127:0] e_train;
        logic [31:0]  e_rdist;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic d, input logic dn,
                                input logic re, input int ad, input logic rdy,
                                input logic bsy, input logic rv, input logic cb,
                                input logic [127:0] tr, input int rd);
        vec_t v;
        v.start = s;  v.dreq = d;  v.done = dn;
        v.e_rd_en = re; v.e_addr = 3'(ad); v.e_ready = rdy; v.e_busy = bsy;
        v.e_rv = rv; v.chk_bus = cb; v.e_train = tr; v.e_rdist = 32'(rd);
        return v;
    endfunction

    vec_t         tbl [15];
    logic [959:0] snap_t, snap_i;
    int           unstable;
    int           bad;
    int           extra;
    logic [31:0]  c_exp_dist;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        {a_start, a_dreq, a_done} = '0; a_type = 2'd2; a_data_type = 2'd3; a_distance = 32'd21;
        {b_start, b_dreq, b_done} = '0; b_type = 2'd1; b_data_type = 2'd1; b_distance = '0;
        {c_start, c_dreq, c_done} = '0; c_type = 2'd3; c_data_type = 2'd2; c_distance = '0;
        for (int i = 0; i < 8; i++) a_train[i] = 32'(i + 1);
        for (int i = 0; i < 4; i++) b_train[i] = 32'(i + 1);
        for (int i = 0; i < 1024; i++) begin
            c_train[i] = $urandom;
            c_inp[i]   = $urandom;
            c_hits[i]  = 0;
        end

        //            st dr dn re ad rdy bsy rv cb train                rdist
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0,                  0);
        tbl[1]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, '0,                  0);
        tbl[2]  = mk(0, 0, 0, 1, 1, 0, 1, 0, 0, '0,                  0);
        tbl[3]  = mk(0, 0, 0, 1, 2, 0, 1, 0, 0, '0,                  0);
        tbl[4]  = mk(0, 0, 0, 1, 3, 0, 1, 0, 0, '0,                  0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, '0,                  0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, words4(1, 2, 3, 4), 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 1, words4(1, 2, 3, 4), 0);
        tbl[8]  = mk(0, 0, 0, 1, 4, 0, 1, 0, 1, '0,                  0);
        tbl[9]  = mk(0, 0, 0, 1, 5, 0, 1, 0, 0, '0,                  0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, '0,                  0);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, words4(5, 6, 0, 0), 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 1, 0, 1, words4(5, 6, 0, 0), 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, '0,                  21);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0,                  21);

        // reset state
        #7;
        check("rst_rd_en",   a_rd_en, 1'b0);
        check("rst_rd_addr", a_rd_addr, '0);
        check("rst_ready",   a_ready, 1'b0);
        check("rst_busy",    a_busy, 1'b0);
        check("rst_rv",      a_rv, 1'b0);
        check("rst_perr",    a_perr, 1'b0);
        check("rst_tdt",     a_tdt, '0);
        check("rst_rdist",   a_rdist, '0);
        check("rst_rtype",   a_rtype, '0);
        check("rst_train",   a_training_data, '0);
        check("rst_c_buses", (c_training_data == '0) && (c_input_data == '0), 1'b1);
        @(negedge clk); rst = 1'b1;

        // cycle-by-cycle trace of a two-burst sample on A
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a_start = tbl[i].start; a_dreq = tbl[i].dreq; a_done = tbl[i].done;
            #1;
            check($sformatf("tbl%0d_rd_en", i), a_rd_en, tbl[i].e_rd_en);
            if (tbl[i].e_rd_en) check($sformatf("tbl%0d_rd_addr", i), a_rd_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_ready", i), a_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d_busy", i), a_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_rv", i), a_rv, tbl[i].e_rv);
            check($sformatf("tbl%0d_rdist", i), a_rdist, tbl[i].e_rdist);
            if (tbl[i].chk_bus) begin
                check($sformatf("tbl%0d_train", i), a_training_data, tbl[i].e_train);
                check($sformatf("tbl%0d_input", i), a_input_data, '0);
            end
        end
        a_start = 0; a_dreq = 0; a_done = 0;
        check("a_tdt",   a_tdt, 2'd2);
        check("a_rtype", a_rtype, 2'd3);

        // B: single burst, straight to WAIT_DONE
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0; #1;
        begin
            int n = 0;
            while (b_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
        end
        check("b_ready", b_ready, 1'b1);
        check("b_train", b_training_data, words4(1, 2, 3, 4));
        check("b_input", b_input_data, '0);
        extra = 0;
        repeat (2) begin
            @(negedge clk); #1;
            if (b_rd_en || b_ready || !b_busy || b_rv) extra++;
        end
        @(negedge clk); b_done = 1'b1; b_distance = 32'd7; #1;
        if (b_rd_en || b_ready || !b_busy || b_rv) extra++;
        check("b_wait_done_quiet", extra, 0);
        @(negedge clk); b_done = 1'b0; #1;
        check("b_rv",    b_rv, 1'b1);
        check("b_rdist", b_rdist, 32'd7);
        check("b_rtype", b_rtype, 2'd1);
        check("b_tdt",   b_tdt, 2'd1);
        @(negedge clk); #1;
        check("b_idle",  b_busy, 1'b0);
        check("b_perr",  b_perr, 1'b0);

        // done during WAIT_REQ of burst 1
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; #1;
        wait_a_ready("perr_ready_b1");
        @(negedge clk); a_done = 1'b1; #1;
        @(negedge clk); a_done = 1'b0; #1;
        check("perr_set",  a_perr, 1'b1);
        check("perr_busy", a_busy, 1'b0);
        extra = (a_rv === 1'b1) ? 1 : 0;
        repeat (5) begin @(negedge clk); #1; if (a_rv) extra++; end
        check("perr_no_result", extra, 0);

        // data_request and done together in WAIT_DONE
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; #1;
        wait_a_ready("both_ready_b1");
        @(negedge clk); a_dreq = 1'b1; #1;
        @(negedge clk); a_dreq = 1'b0; #1;
        wait_a_ready("both_ready_b2");
        @(negedge clk); a_dreq = 1'b1; a_done = 1'b1; a_distance = 32'd33; #1;
        @(negedge clk); a_dreq = 1'b0; a_done = 1'b0; #1;
        check("both_rv",    a_rv, 1'b1);
        check("both_rd_en", a_rd_en, 1'b0);
        check("both_rdist", a_rdist, 32'd33);
        extra = 0;
        repeat (8) begin @(negedge clk); #1; if (a_rd_en || a_ready) extra++; end
        check("both_no_fetch", extra, 0);
        check("both_idle",     a_busy, 1'b0);
        check("perr_sticky",   a_perr, 1'b1);

        // reset mid-FETCH
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; #1;
        @(negedge clk); #1;
        check("mid_fetch_rd_en", a_rd_en, 1'b1);
        #2; rst = 1'b0; #1;
        check("arst_rd_en", a_rd_en, 1'b0);
        check("arst_addr",  a_rd_addr, '0);
        check("arst_ready", a_ready, 1'b0);
        check("arst_busy",  a_busy, 1'b0);
        check("arst_perr",  a_perr, 1'b0);
        check("arst_train", a_training_data, '0);
        check("arst_rdist", a_rdist, '0);
        check("arst_tdt",   a_tdt, '0);
        @(negedge clk); rst = 1'b1; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; #1;
        check("restart_rd_en", a_rd_en, 1'b1);
        check("restart_addr",  a_rd_addr, 3'd0);
        @(negedge clk); #1;
        check("restart_addr1", a_rd_addr, 3'd1);

        // C: defaults, 20 bursts of random data
        c_rd_total = 0; c_ready_cnt = 0; unstable = 0;
        for (int i = 0; i < 1024; i++) c_hits[i] = 0;
        @(negedge clk); c_start = 1'b1;
        @(negedge clk); c_start = 1'b0; #1;
        for (int b = 0; b < 20; b++) begin
            wait_c_ready($sformatf("c_ready_%0d", b));
            bad = 0;
            for (int k = 0; k < 30; k++) begin
                if (c_training_data[k*32 +: 32] !== c_train[b*30 + k]) bad++;
                if (c_input_data[k*32 +: 32]    !== c_inp[b*30 + k])   bad++;
            end
            check($sformatf("c_burst%0d_words", b), bad, 0);
            snap_t = c_training_data; snap_i = c_input_data;
            repeat (2) begin
                @(negedge clk); #1;
                if (c_training_data !== snap_t || c_input_data !== snap_i) unstable++;
            end
            if (b < 19) begin
                @(negedge clk); c_dreq = 1'b1; #1;
                if (c_training_data !== snap_t || c_input_data !== snap_i) unstable++;
                @(negedge clk); c_dreq = 1'b0; #1;
            end
        end
        c_exp_dist = $urandom;
        @(negedge clk); c_done = 1'b1; c_distance = c_exp_dist; #1;
        @(negedge clk); c_done = 1'b0; #1;
        check("c_rv",       c_rv, 1'b1);
        check("c_rdist",    c_rdist, c_exp_dist);
        check("c_rtype",    c_rtype, 2'd2);
        check("c_tdt",      c_tdt, 2'd3);
        check("c_stable",   unstable, 0);
        check("c_ready_cnt", c_ready_cnt, 20);
        check("c_rd_total", c_rd_total, 600);
        bad = 0;
        for (int i = 0; i < 600; i++) if (c_hits[i] != 1) bad++;
        check("c_addr_once", bad, 0);
        @(negedge clk); #1;
        check("c_idle", c_busy, 1'b0);
        check("c_perr", c_perr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
